// File: rtl/mips_mem_pkg.sv
// Shared constants and types for the data-memory load/store unit.
package mips_mem_pkg;

  localparam int unsigned CAPACITY = 512;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane steering: store merge into a memory word and load extract/extend.
module lsu_lane_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic        signed_i,
  output logic [31:0] merged_o,
  output logic [31:0] rdata_o
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sh  = {lane_i, 3'b000};
  assign half_sh  = {lane_i[1], 4'b0000};
  assign byte_sel = word_i[byte_sh +: 8];
  assign half_sel = word_i[half_sh +: 16];

  always_comb begin
    merged_o = word_i;
    rdata_o  = word_i;
    case (size_i)
      SIZE_BYTE: begin
        merged_o[byte_sh +: 8] = wdata_i[7:0];
        rdata_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      end
      SIZE_HALF: begin
        merged_o[half_sh +: 16] = wdata_i[15:0];
        rdata_o = {{16{signed_i & half_sel[15]}}, half_sel};
      end
      SIZE_WORD: merged_o = wdata_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/data_memory_lsu.sv
// Load/store unit in front of a word-wide data memory (async read, sync write).
// Optional LSU_FAULT_CNT_EN adds a saturating count of accepted faulting requests.
module data_memory_lsu #(
  parameter int unsigned CAPACITY = mips_mem_pkg::CAPACITY
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef LSU_FAULT_CNT_EN
  output logic [15:0]           fault_cnt,
`endif
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [$clog2(CAPACITY)-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_we,
  input  logic [31:0]           mem_rdata
);

  import mips_mem_pkg::lsu_state_t;
  import mips_mem_pkg::IDLE;
  import mips_mem_pkg::READ;
  import mips_mem_pkg::WRITE;
  import mips_mem_pkg::RESP;
  import mips_mem_pkg::SIZE_HALF;
  import mips_mem_pkg::SIZE_WORD;

  localparam int unsigned ADDR_WIDTH      = $clog2(CAPACITY);
  localparam int unsigned BYTE_ADDR_WIDTH = ADDR_WIDTH + 2;

  lsu_state_t            state_q, state_d;
  logic                  we_q;
  logic                  signed_q;
  logic [1:0]            size_q;
  logic [1:0]            lane_q;
  logic [31:0]           wdata_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [31:0]           mem_wdata_q;
  logic [31:0]           resp_rdata_q;
  logic                  resp_err_q;

  logic                  accept;
  logic                  fault;
  logic [31:0]           merged;
  logic [31:0]           extracted;

  assign accept = req_valid && (state_q == IDLE);
  assign fault  = (req_size == 2'b11)
               || ((req_size == SIZE_HALF) && req_addr[0])
               || ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00))
               || (req_addr[31:BYTE_ADDR_WIDTH] != '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (fault)                               state_d = RESP;
          else if (!req_we)                        state_d = READ;
          else if (req_size == SIZE_WORD)          state_d = WRITE;
          else                                     state_d = READ;
        end
      end
      READ:    state_d = we_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  lsu_lane_align u_align (
    .word_i   (mem_rdata),
    .wdata_i  (wdata_q),
    .size_i   (size_q),
    .lane_i   (lane_q),
    .signed_i (signed_q),
    .merged_o (merged),
    .rdata_o  (extracted)
  );

  // The read word is merged straight into mem_wdata_q at the READ edge, which
  // is what a separate rd_q capture followed by a merge in WRITE would produce.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      signed_q     <= 1'b0;
      size_q       <= 2'b00;
      lane_q       <= 2'b00;
      wdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q         <= req_we;
            size_q       <= req_size;
            signed_q     <= req_signed;
            lane_q       <= req_addr[1:0];
            wdata_q      <= req_wdata;
            resp_rdata_q <= '0;
            resp_err_q   <= fault;
            if (!fault) begin
              mem_addr_q <= req_addr[BYTE_ADDR_WIDTH-1:2];
              if (req_we && (req_size == SIZE_WORD)) mem_wdata_q <= req_wdata;
            end
          end
        end
        READ: begin
          if (we_q) mem_wdata_q  <= merged;
          else      resp_rdata_q <= extracted;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_we     = (state_q == WRITE);
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

`ifdef LSU_FAULT_CNT_EN
  logic [15:0] fault_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_cnt_q <= '0;
    end else if (accept && fault && (fault_cnt_q != 16'hFFFF)) begin
      fault_cnt_q <= fault_cnt_q + 16'd1;
    end
  end

  assign fault_cnt = fault_cnt_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule
